// File: rtl/mux_bank_arbiter.sv
// Three-requester round-robin arbiter for a shared 4-lane mux bank, with grant hold and gap timing.
// Optional macro MUX_ARB_FIXED_PRIO_EN: requester 0 always wins, requesters 1 and 2 share round-robin.
module mux_bank_arbiter #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic [1:0] hold;
  logic       sel_req;

  assign clk     = io_in[0];
  assign rst     = io_in[1];
  assign req     = io_in[4:2];
  assign hold    = io_in[6:5];
  assign sel_req = io_in[7];

  state_e     state_q, state_d;
  logic [2:0] gnt_q, gnt_d;
  logic       sel_q, sel_d;
  logic [2:0] count_q, count_d;
  // Requester searched first at the next arbitration (0..2).
  logic [1:0] prio_q, prio_d;

  logic [2:0] arb_req;
  logic [2:0] rot_req;
  logic [1:0] offset;
  logic       win_vld;
  logic [1:0] win_idx;
  logic [2:0] win_oh;
  logic       arbitrate;

`ifdef MUX_ARB_FIXED_PRIO_EN
  // Masking requester 0 out of the rotation leaves 1 and 2 alternating between themselves.
  assign arb_req = {req[2:1], 1'b0};
`else
  assign arb_req = req;
`endif

  // Rotate so that bit k is the requester at position k of the current search order.
  always_comb begin
    rot_req = arb_req;
    case (prio_q)
      2'd1:    rot_req = {arb_req[0], arb_req[2], arb_req[1]};
      2'd2:    rot_req = {arb_req[1], arb_req[0], arb_req[2]};
      default: rot_req = arb_req;
    endcase
  end

  always_comb begin
    offset  = 2'd0;
    win_vld = 1'b1;
    if (rot_req[0]) begin
      offset = 2'd0;
    end else if (rot_req[1]) begin
      offset = 2'd1;
    end else if (rot_req[2]) begin
      offset = 2'd2;
    end else begin
      win_vld = 1'b0;
    end
  end

  always_comb begin
    win_idx = 2'd0;
    case ({1'b0, prio_q} + {1'b0, offset})
      3'd1, 3'd4: win_idx = 2'd1;
      3'd2:       win_idx = 2'd2;
      default:    win_idx = 2'd0;
    endcase
`ifdef MUX_ARB_FIXED_PRIO_EN
    if (req[0]) begin
      win_idx = 2'd0;
    end
`endif
  end

  always_comb begin
    win_oh = 3'b000;
    case (win_idx)
      2'd0:    win_oh = 3'b001;
      2'd1:    win_oh = 3'b010;
      2'd2:    win_oh = 3'b100;
      default: win_oh = 3'b000;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    count_d   = count_q;
    prio_d    = prio_q;
    arbitrate = 1'b0;

    unique case (state_q)
      StIdle: arbitrate = 1'b1;
      StGrant: begin
        if (((req & gnt_q) == 3'b000) || (count_q == 3'd1)) begin
          gnt_d   = 3'b000;
          count_d = 3'd0;
          if (GAP_CYCLES > 0) begin
            state_d = StGap;
            count_d = 3'(GAP_CYCLES);
          end else begin
            state_d = StIdle;
          end
        end else begin
          count_d = count_q - 3'd1;
        end
      end
      StGap: begin
        // The gap's final edge doubles as the idle arbitration edge.
        if (count_q <= 3'd1) begin
          state_d   = StIdle;
          count_d   = 3'd0;
          arbitrate = 1'b1;
        end else begin
          count_d = count_q - 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (arbitrate && (win_vld || (arb_req != req))) begin
      state_d = StGrant;
      gnt_d   = win_oh;
      sel_d   = sel_req;
      count_d = {1'b0, hold} + 3'd1;
      prio_d  = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= 3'b000;
      sel_q   <= 1'b0;
      count_q <= 3'd0;
      prio_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      count_q <= count_d;
      prio_q  <= prio_d;
    end
  end

  assign io_out = {(sel_q ? 4'b1000 : 4'b0111), sel_q, gnt_q};

endmodule

// File: tb/tb_mux_bank_arbiter.sv
// Randomized and directed bench for mux_bank_arbiter; two instances (GAP_CYCLES=1 and 0) share
// stimulus and are each checked against a requester-level reference model.
module tb_mux_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] req = 3'b000;
  logic [1:0] hold = 2'b00;
  logic       sel_req = 1'b0;
  logic [7:0] io_in;
  logic [7:0] out_gap1;
  logic [7:0] out_gap0;

  int n_total = 0;
  int n_bad   = 0;

  assign io_in = {sel_req, hold, req, rst, clk};

  always #5 clk = ~clk;

  mux_bank_arbiter #(.GAP_CYCLES(1)) u_dut_gap1 (
    .io_in  (io_in),
    .io_out (out_gap1)
  );

  mux_bank_arbiter #(.GAP_CYCLES(0)) u_dut_gap0 (
    .io_in  (io_in),
    .io_out (out_gap0)
  );

  // Reference model state, one slot per instance.
  int   gap_len[2] = '{1, 0};
  int   owner[2];      // granted requester, -1 if none
  int   left[2];       // grant cycles remaining including the current one
  int   gap_left[2];   // gap cycles remaining
  int   first[2];      // first requester in the next search order
  logic m_sel[2];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int start, input logic [2:0] r);
    logic [2:0] rr;
    rr = r;
`ifdef MUX_ARB_FIXED_PRIO_EN
    if (rr[0]) return 0;
    rr[0] = 1'b0;
`endif
    for (int k = 0; k < 3; k++) begin
      if (rr[(start + k) % 3]) return (start + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [7:0] expected(input int d);
    logic [2:0] g;
    g = 3'b000;
    if (owner[d] >= 0) g[owner[d]] = 1'b1;
    return {(m_sel[d] ? 4'b1000 : 4'b0111), m_sel[d], g};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      owner[d] = -1;
      left[d] = 0;
      gap_left[d] = 0;
      first[d] = 0;
      m_sel[d] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit arb;
      int w;
      arb = 1'b0;
      if (rst) begin
        owner[d] = -1; left[d] = 0; gap_left[d] = 0; first[d] = 0; m_sel[d] = 1'b0;
      end else begin
        if (owner[d] >= 0) begin
          if (!req[owner[d]] || left[d] == 1) begin
            owner[d] = -1;
            gap_left[d] = gap_len[d];
          end else begin
            left[d]--;
          end
        end else if (gap_left[d] > 0) begin
          gap_left[d]--;
          if (gap_left[d] == 0) arb = 1'b1;
        end else begin
          arb = 1'b1;
        end
        if (arb) begin
          w = pick(first[d], req);
          if (w >= 0) begin
            owner[d] = w;
            left[d] = int'(hold) + 1;
            m_sel[d] = sel_req;
            first[d] = (w + 1) % 3;
          end
        end
      end
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check({tag, "_gap1"}, out_gap1, expected(0));
    check({tag, "_gap0"}, out_gap0, expected(1));
  endtask

  task automatic run(input string tag, input int n, input logic [2:0] r, input logic [1:0] h,
                     input logic s);
    req = r;
    hold = h;
    sel_req = s;
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  // Asserts reset away from the clock edge and checks outputs before any edge arrives.
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check({tag, "_imm1"}, out_gap1, 8'b0111_0000);
    check({tag, "_imm0"}, out_gap0, 8'b0111_0000);
    cycle(tag);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    pulse_reset("reset");

    run("idle", 10, 3'b000, 2'b00, 1'b0);
    run("hold4_sel1", 7, 3'b010, 2'b11, 1'b1);
    run("drain", 2, 3'b000, 2'b00, 1'b0);
    run("rr_all", 10, 3'b111, 2'b00, 1'b0);
    run("drain", 2, 3'b000, 2'b00, 1'b0);
    // Granted on the first edge, held two cycles, then released early.
    run("early_rel", 3, 3'b001, 2'b11, 1'b0);
    run("early_rel", 3, 3'b000, 2'b11, 1'b0);
    // Reset lands during the third cycle of a four-cycle grant.
    run("pre_rst", 3, 3'b001, 2'b11, 1'b1);
    pulse_reset("mid_grant_rst");
    run("post_rst", 6, 3'b111, 2'b00, 1'b0);
    run("drain", 3, 3'b000, 2'b00, 1'b0);
    run("hold2_pair", 8, 3'b011, 2'b01, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      req = 3'($urandom_range(0, 7));
      hold = 2'($urandom_range(0, 3));
      sel_req = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset("rand_rst");
      end else begin
        cycle("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_bank_arbiter.md
MUX_BANK_ARBITER -- requirements
Module: mux_bank_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 1, meaning idle cycles forced between consecutive grants (legal 0..3).
REQ-002 io_in[0]  input  1  clock; rising-edge active; single clock domain.
REQ-003 io_in[1]  input  1  reset; asynchronous, active-high.
REQ-004 io_in[4:2]  input  3  req[2:0]; level requests from three requesters for the shared mux bank.
REQ-005 io_in[6:5]  input  2  hold; grant length minus one, sampled at grant.
REQ-006 io_in[7]  input  1  sel_req; mux-bank select wanted by the winning requester, sampled at grant.
REQ-007 io_out[2:0]  output  3  gnt[2:0]; one-hot registered grant, at most one bit set.
REQ-008 io_out[3]  output  1  sel; registered shared select driving all four mux lanes.
REQ-009 io_out[7:4]  output  4  lane[3:0]; mux-bank outputs: sel=0 -> 4'b0111, sel=1 -> 4'b1000, combinational from sel only.

Function
REQ-010 FSM states SHALL be IDLE, GRANT, GAP; encoding free.
REQ-011 IDLE: no req -> stay IDLE; any req high at a rising edge -> GRANT on that edge, gnt set to winner.
REQ-012 Grant latency SHALL be exactly one edge: req sampled high at edge N -> gnt visible after edge N.
REQ-013 On entry to GRANT: count loaded with hold+1 (1..4); sel loaded with sel_req; both sampled on the granting edge.
REQ-014 GRANT SHALL last min(hold+1, cycles until granted req is sampled low) cycles.
REQ-015 Granted req sampled low at an edge -> gnt cleared on that same edge (early release).
REQ-016 Count expiry -> gnt cleared on the edge where count reaches zero, even if req still high.
REQ-017 Leaving GRANT: GAP_CYCLES>0 -> GAP for GAP_CYCLES cycles, gnt=0; GAP_CYCLES=0 -> IDLE; this edge SHALL NOT issue a new grant.
REQ-018 GAP: requests ignored; on expiry -> IDLE.
REQ-019 Round-robin: after granting requester i, search priority order SHALL be i+1, i+2, i (mod 3).
REQ-020 Simultaneous requests in IDLE: winner by current round-robin order; losers wait, no queuing state beyond req levels.
REQ-021 Non-granted req changes during GRANT/GAP SHALL NOT affect gnt, sel or count.
REQ-022 sel SHALL change only on a granting edge; holds last value through GAP and IDLE.
REQ-023 hold and sel_req changes after the granting edge SHALL be ignored.

Reset
REQ-024 Reset asserted: state=IDLE, gnt=3'b000, sel=0, count=0, RR pointer=requester 0 first; immediate, clock-independent.
REQ-025 Reset outputs: io_out=8'b0111_0000.
REQ-026 Reset mid-GRANT or mid-GAP SHALL abort without completing hold or gap.
REQ-027 First edge after reset release SHALL behave as IDLE with priority order 0,1,2.

Configuration
REQ-028 Macro MUX_ARB_FIXED_PRIO_EN defined: requester 0 SHALL always win when its req is high in IDLE; requesters 1,2 round-robin between themselves.
REQ-029 Macro undefined: pure three-way round-robin per REQ-019.
REQ-030 Macro SHALL NOT change ports, latency, FSM timing or reset values.

Verification
REQ-031 Reset, no req, 10 clocks -> io_out stays 8'b0111_0000.
REQ-032 req=3'b010, hold=2'b11, sel_req=1 held high -> gnt=3'b010 for exactly 4 cycles, sel=1, lane=4'b1000; then gnt=0 for 1 cycle (GAP_CYCLES=1).
REQ-033 req=3'b111 held, hold=0 -> grant sequence 001,010,100,001 each 1 cycle separated by 1 gap cycle (macro undefined); with MUX_ARB_FIXED_PRIO_EN -> 001 every grant.
REQ-034 req=3'b001, hold=3, req dropped after 2 granted cycles -> gnt cleared on that edge, total grant 2 cycles.
REQ-035 Reset pulsed during 3rd cycle of a 4-cycle grant -> gnt=0, sel=0, lane=4'b0111 immediately; next grant uses order 0,1,2.
REQ-036 GAP_CYCLES=0, req=3'b011 held, hold=1 -> gnt 001 x2, 0 x1 (release edge), 010 x2.
